// File: rtl/r22sdf_pkg.sv
// Shared constants and the Q1.15 round/saturate helper for the radix-2^2 SDF datapath.
// The twiddle multiplier and the butterflies both use round_sat.
package r22sdf_pkg;

  localparam int WIDTH = 16;
  localparam int LOG_N = 6;
  localparam int LOG_M = 6;

  // Round half-up at bit WIDTH-1, then clamp anything outside the Q1.15 range.
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [2*WIDTH:0] sum);
    logic signed [2*WIDTH:0] t;
    logic [WIDTH-1:0]        r;
    t = sum + $signed({{(WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}});
    if (!t[2*WIDTH] && (t[2*WIDTH-1:2*WIDTH-2] != 2'b00)) begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (t[2*WIDTH] && (t[2*WIDTH-1:2*WIDTH-2] != 2'b11)) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = t[2*WIDTH-2:WIDTH-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_mult_cmult.sv
// Two-stage registered complex multiplier: partial products, then sum/round/saturate.
// A bypass flag routes the raw input to the output for the trivial twiddle.
module cmult #(
  parameter int WIDTH = r22sdf_pkg::WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic                    in_byp,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic                    out_en,
  output logic        [WIDTH-1:0] out_re,
  output logic        [WIDTH-1:0] out_im
);
  import r22sdf_pkg::*;

  logic signed [2*WIDTH-1:0] rr_d, rr_q, ii_d, ii_q, ri_d, ri_q, ir_d, ir_q;
  logic                      en2_d, en2_q, byp2_d, byp2_q;
  logic        [WIDTH-1:0]   bre_d, bre_q, bim_d, bim_q;
  logic signed [2*WIDTH:0]   sum_re_s, sum_im_s;
  logic                      en3_d, en3_q;
  logic        [WIDTH-1:0]   re3_d, re3_q, im3_d, im3_q;

  // S2 next state: four partial products plus the bypass copy of the sample
  always_comb begin
    rr_d   = (2*WIDTH)'(a_re) * (2*WIDTH)'(b_re);
    ii_d   = (2*WIDTH)'(a_im) * (2*WIDTH)'(b_im);
    ri_d   = (2*WIDTH)'(a_re) * (2*WIDTH)'(b_im);
    ir_d   = (2*WIDTH)'(a_im) * (2*WIDTH)'(b_re);
    en2_d  = in_en;
    byp2_d = in_byp;
    bre_d  = a_re;
    bim_d  = a_im;
  end

  // S3 next state: outputs only change on a valid sample, otherwise they hold
  always_comb begin
    sum_re_s = (2*WIDTH+1)'(rr_q) - (2*WIDTH+1)'(ii_q);
    sum_im_s = (2*WIDTH+1)'(ri_q) + (2*WIDTH+1)'(ir_q);
    en3_d    = en2_q;
    re3_d    = re3_q;
    im3_d    = im3_q;
    if (en2_q) begin
      if (byp2_q) begin
        re3_d = bre_q;
        im3_d = bim_q;
      end else begin
        re3_d = round_sat(sum_re_s);
        im3_d = round_sat(sum_im_s);
      end
    end else begin
      re3_d = re3_q;
      im3_d = im3_q;
    end
  end

  // S2/S3 pipeline registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= '0; ii_q <= '0; ri_q <= '0; ir_q <= '0;
      en2_q <= 1'b0; byp2_q <= 1'b0; bre_q <= '0; bim_q <= '0;
      en3_q <= 1'b0; re3_q <= '0; im3_q <= '0;
    end else begin
      rr_q <= rr_d; ii_q <= ii_d; ri_q <= ri_d; ir_q <= ir_d;
      en2_q <= en2_d; byp2_q <= byp2_d; bre_q <= bre_d; bim_q <= bim_d;
      en3_q <= en3_d; re3_q <= re3_d; im3_q <= im3_d;
    end
  end

  assign out_en = en3_q;
  assign out_re = re3_q;
  assign out_im = im3_q;

endmodule

// File: rtl/twiddle_mult.sv
// Twiddle consumer for one radix-2^2 SDF stage pair: frame counter, twiddle address,
// alignment with the external table, and a 3-cycle complex multiply with bypass.
module twiddle_mult #(
  parameter int N     = 2**r22sdf_pkg::LOG_N,
  parameter int M     = 2**r22sdf_pkg::LOG_M,
  parameter int WIDTH = r22sdf_pkg::WIDTH,
  parameter int TW_FF = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  di_en,
  input  logic [WIDTH-1:0]      di_re,
  input  logic [WIDTH-1:0]      di_im,
  output logic [$clog2(N)-1:0]  tw_addr,
  input  logic [WIDTH-1:0]      tw_re,
  input  logic [WIDTH-1:0]      tw_im,
  output logic                  do_en,
  output logic [WIDTH-1:0]      do_re,
  output logic [WIDTH-1:0]      do_im
);
  import r22sdf_pkg::*;

  localparam int ADDR_W = $clog2(N);
  localparam int CNT_W  = $clog2(M);

  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [1:0]        sel_s;
  logic [ADDR_W-1:0] num_s, prod_s, addr_s;
  logic              s1_en_d, s1_en_q, s1_byp_d, s1_byp_q;
  logic [WIDTH-1:0]  s1_re_d, s1_re_q, s1_im_d, s1_im_q;
  logic [WIDTH-1:0]  tw_re_s, tw_im_s;

  // Quarter-frame order 0,2,1,3 comes from swapping the two counter MSBs
  assign sel_s = {cnt_q[CNT_W-2], cnt_q[CNT_W-1]};

  if (CNT_W > 2) begin : g_num
    assign num_s = ADDR_W'(cnt_q[CNT_W-3:0]) << (ADDR_W - CNT_W);
  end else begin : g_num_zero
    assign num_s = '0;
  end

  // Counter advance, twiddle address and S1 next state
  always_comb begin
    prod_s = num_s * ADDR_W'(sel_s);
    if (di_en) begin
      cnt_d  = cnt_q + CNT_W'(1);
      addr_s = prod_s;
    end else begin
      cnt_d  = cnt_q;
      addr_s = '0;
    end
    s1_en_d  = di_en;
    s1_byp_d = (addr_s == '0);
    s1_re_d  = di_re;
    s1_im_d  = di_im;
  end

  // Frame counter and S1 data/flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      s1_en_q  <= 1'b0;
      s1_byp_q <= 1'b0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      s1_en_q  <= s1_en_d;
      s1_byp_q <= s1_byp_d;
      s1_re_q  <= s1_re_d;
      s1_im_q  <= s1_im_d;
    end
  end

  assign tw_addr = addr_s;

  // A registered table already lines up with S1; a combinational one is captured here
  if (TW_FF == 0) begin : g_tw_cap
    logic [WIDTH-1:0] tw_re_d, tw_re_q, tw_im_d, tw_im_q;

    // Next-state copy of the combinational table output
    always_comb begin
      tw_re_d = tw_re;
      tw_im_d = tw_im;
    end

    // Twiddle capture alongside the S1 sample
    always_ff @(posedge clock) begin
      if (reset) begin
        tw_re_q <= '0;
        tw_im_q <= '0;
      end else begin
        tw_re_q <= tw_re_d;
        tw_im_q <= tw_im_d;
      end
    end

    assign tw_re_s = tw_re_q;
    assign tw_im_s = tw_im_q;
  end else begin : g_tw_pass
    assign tw_re_s = tw_re;
    assign tw_im_s = tw_im;
  end

  cmult #(.WIDTH(WIDTH)) u_cmult (
    .clock  (clock),
    .reset  (reset),
    .in_en  (s1_en_q),
    .in_byp (s1_byp_q),
    .a_re   (s1_re_q),
    .a_im   (s1_im_q),
    .b_re   (tw_re_s),
    .b_im   (tw_im_s),
    .out_en (do_en),
    .out_re (do_re),
    .out_im (do_im)
  );

endmodule

// File: tb/tb_twiddle_mult.sv
// Scoreboard bench for twiddle_mult: one instance with a registered table, one with a
// combinational table, driven identically and checked against the same expectations.
module tb_twiddle_mult;

  typedef struct {
    int          due;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, di_en;
  logic [15:0] di_re, di_im;
  logic [5:0]  tw_addr_ff, tw_addr_cb;
  logic [15:0] tw_re_ff, tw_im_ff, tw_re_cb, tw_im_cb;
  logic        do_en_ff, do_en_cb;
  logic [15:0] do_re_ff, do_im_ff, do_re_cb, do_im_cb;

  logic [15:0] rom_re [64];
  logic [15:0] rom_im [64];

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          cnt_m  = 0;
  logic [15:0] last_re = 16'h0000;
  logic [15:0] last_im = 16'h0000;

  always #5 clock = ~clock;

  twiddle_mult #(.N(64), .M(64), .WIDTH(16), .TW_FF(1)) dut_ff (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .tw_addr(tw_addr_ff), .tw_re(tw_re_ff), .tw_im(tw_im_ff),
    .do_en(do_en_ff), .do_re(do_re_ff), .do_im(do_im_ff)
  );

  twiddle_mult #(.N(64), .M(64), .WIDTH(16), .TW_FF(0)) dut_cb (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .tw_addr(tw_addr_cb), .tw_re(tw_re_cb), .tw_im(tw_im_cb),
    .do_en(do_en_cb), .do_re(do_re_cb), .do_im(do_im_cb)
  );

  // Registered table model for the TW_FF=1 instance
  always @(posedge clock) begin
    tw_re_ff <= rom_re[tw_addr_ff];
    tw_im_ff <= rom_im[tw_addr_ff];
  end

  assign tw_re_cb = rom_re[tw_addr_cb];
  assign tw_im_cb = rom_im[tw_addr_cb];

  function automatic int exp_addr(input int c);
    int q = c / 16;
    int j = c % 16;
    int k;
    case (q)
      0:       k = 0;
      1:       k = 2;
      2:       k = 1;
      default: k = 3;
    endcase
    return (j * k) % 64;
  endfunction

  function automatic logic [15:0] rs(input longint p);
    longint t;
    t = (p + 64'sd16384) >>> 15;
    if (t > 64'sd32767)  t = 64'sd32767;
    if (t < -64'sd32768) t = -64'sd32768;
    return t[15:0];
  endfunction

  task automatic drive(input logic en, input logic [15:0] re, input logic [15:0] im, input logic rst);
    int     a;
    exp_t   ex;
    exp_t   got;
    longint dr, dI, wr, wi;
    reset = rst; di_en = en; di_re = re; di_im = im;
    #1;
    a = en ? exp_addr(cnt_m) : 0;
    checks++;
    if (tw_addr_ff !== 6'(a) || tw_addr_cb !== 6'(a)) begin
      errors++;
      $display("FAIL tw_addr cnt=%0d: got %0d/%0d, want %0d", cnt_m, tw_addr_ff, tw_addr_cb, a);
    end
    if (rst) begin
      cnt_m = 0;
    end else if (en) begin
      ex.due = cyc + 3;
      if (a == 0) begin
        ex.re = re;
        ex.im = im;
      end else begin
        dr = longint'($signed(re));
        dI = longint'($signed(im));
        wr = longint'($signed(rom_re[a]));
        wi = longint'($signed(rom_im[a]));
        ex.re = rs(dr * wr - dI * wi);
        ex.im = rs(dr * wi + dI * wr);
      end
      sb.push_back(ex);
      cnt_m = (cnt_m + 1) % 64;
    end
    @(posedge clock); #1;
    cyc++;
    if (rst) sb.delete();
    checks++;
    if (do_en_cb !== do_en_ff) begin
      errors++;
      $display("FAIL do_en_align cyc=%0d: ff=%b cb=%b", cyc, do_en_ff, do_en_cb);
    end
    if (rst) begin
      checks++;
      if ({do_en_ff, do_re_ff, do_im_ff, do_en_cb, do_re_cb, do_im_cb} !== 66'd0) begin
        errors++;
        $display("FAIL reset_out cyc=%0d: en=%b re=%h im=%h, want 0", cyc, do_en_ff, do_re_ff, do_im_ff);
      end
      last_re = 16'h0000;
      last_im = 16'h0000;
    end else if (do_en_ff === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_do_en cyc=%0d: got do_en=1, want 0", cyc);
      end else begin
        got = sb.pop_front();
        checks++;
        if (got.due != cyc) begin
          errors++;
          $display("FAIL latency: output at cyc %0d, want %0d", cyc, got.due);
        end
        checks++;
        if (do_re_ff !== got.re || do_im_ff !== got.im) begin
          errors++;
          $display("FAIL data_ff cyc=%0d: got (%h,%h), want (%h,%h)", cyc, do_re_ff, do_im_ff, got.re, got.im);
        end
        checks++;
        if (do_re_cb !== got.re || do_im_cb !== got.im) begin
          errors++;
          $display("FAIL data_cb cyc=%0d: got (%h,%h), want (%h,%h)", cyc, do_re_cb, do_im_cb, got.re, got.im);
        end
        last_re = got.re;
        last_im = got.im;
      end
    end else begin
      checks++;
      if (do_re_ff !== last_re || do_im_ff !== last_im || do_re_cb !== last_re || do_im_cb !== last_im) begin
        errors++;
        $display("FAIL hold cyc=%0d: got (%h,%h)/(%h,%h), want (%h,%h)", cyc, do_re_ff, do_im_ff, do_re_cb, do_im_cb, last_re, last_im);
      end
      checks++;
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        errors++;
        $display("FAIL missing_do_en cyc=%0d: got do_en=0, want 1 (due %0d)", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic advance_to(input int target);
    while (cnt_m != target) drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom), 1'b1);
  endtask

  task automatic test_addr_seq();
    for (int i = 0; i < 65; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_multiply();
    advance_to(17);
    drive(1'b1, 16'h4000, 16'h0000, 1'b0);
  endtask

  task automatic test_bypass();
    advance_to(5);
    drive(1'b1, 16'h8000, 16'h7FFF, 1'b0);
  endtask

  task automatic test_saturation();
    advance_to(24);
    drive(1'b1, 16'h8000, 16'h0000, 1'b0);
  endtask

  task automatic test_gaps();
    logic [4:0] pat;
    pat = 5'b10110;
    advance_to(40);
    for (int r = 0; r < 2; r++)
      for (int i = 4; i >= 0; i--) drive(pat[i], 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    advance_to(37);
    drive(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 6; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs never appeared, want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_re[i] = 16'($urandom);
      rom_im[i] = 16'($urandom);
    end
    rom_re[0]  = 16'h0000; rom_im[0]  = 16'h0000;
    rom_re[2]  = 16'h7D8A; rom_im[2]  = 16'hE707;
    rom_re[16] = 16'h0000; rom_im[16] = 16'h8000;
    reset = 1'b1; di_en = 1'b0; di_re = 16'h0000; di_im = 16'h0000;
    @(posedge clock); #1;
    test_reset();
    test_addr_seq();
    test_multiply();
    test_bypass();
    test_saturation();
    test_gaps();
    test_reset_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
